// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_sequencer
// Brief    : Latches an operand pair, sweeps the ALU select through every
//            opcode and streams each sampled result on a valid/ready port.
//            Optional macro ALU_OP_SEQUENCER_SELFCHECK_EN adds a result checker.
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
    parameter int WIDTH   = 8,
    parameter int NUM_OPS = 6,
    parameter int SETTLE  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [2:0]       res_op,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int               CNT_W     = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
    localparam logic [2:0]       c_last_op = 3'(NUM_OPS - 1);
    localparam logic [CNT_W-1:0] c_settle  = CNT_W'(SETTLE);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_OUTPUT = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_capture;

    // Result is sampled on the last cycle of the settle window.
    assign w_capture = (r_state == S_DRIVE) && (r_cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            res_data  <= '0;
            res_op    <= '0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        alu_a   <= a_in;
                        alu_b   <= b_in;
                        alu_sel <= 3'd0;
                        r_cnt   <= c_settle;
                        busy    <= 1'b1;
                        r_state <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (w_capture) begin
                        res_data  <= alu_result;
                        res_op    <= alu_sel;
                        res_valid <= 1'b1;
                        r_state   <= S_OUTPUT;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_OUTPUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (alu_sel == c_last_op) begin
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            alu_sel <= alu_sel + 3'd1;
                            r_cnt   <= c_settle;
                            r_state <= S_DRIVE;
                        end
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef ALU_OP_SEQUENCER_SELFCHECK_EN
    logic r_err;

    function automatic logic [WIDTH-1:0] f_expect(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [2:0]       sel
    );
        case (sel)
            3'd0:    f_expect = a + b;
            3'd1:    f_expect = a + WIDTH'(1);
            3'd2:    f_expect = a - b;
            3'd3:    f_expect = a ^ b;
            3'd4:    f_expect = a | b;
            3'd5:    f_expect = a & b;
            default: f_expect = '0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_capture && (alu_result != f_expect(alu_a, alu_b, alu_sel))) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_op_sequencer
// Brief    : Self-checking bench for alu_op_sequencer with an ALU stand-in.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

    localparam int WIDTH   = 8;
    localparam int NUM_OPS = 6;
    localparam int SETTLE  = 1;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_sel;
    logic [WIDTH-1:0] alu_result;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic [2:0]       res_op;
    logic             busy;
    logic             done;
    logic             err;

    bit fault_op4;
    int n_cmp;
    int n_fail;

    alu_op_sequencer #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS), .SETTLE(SETTLE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a_in       (a_in),
        .b_in       (b_in),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_op     (res_op),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Opcode table evaluated with plain integer arithmetic, modulo 256.
    function automatic logic [7:0] ref_op(input int a, input int b, input int op);
        int r;
        case (op)
            0:       r = a + b;
            1:       r = a + 1;
            2:       r = a - b;
            3:       r = a ^ b;
            4:       r = a | b;
            5:       r = a & b;
            default: r = 0;
        endcase
        return 8'(r & 255);
    endfunction

    // ALU stand-in; fault_op4 models a broken OR path.
    always_comb begin
        alu_result = ref_op(int'(alu_a), int'(alu_b), int'(alu_sel));
        if (fault_op4 && alu_sel == 3'd4) alu_result = 8'h00;
    end

    function automatic bit exp_err(input int op);
`ifdef ALU_OP_SEQUENCER_SELFCHECK_EN
        return fault_op4 && (op >= 4);
`else
        return 1'b0;
`endif
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; res_ready = 1'b1; a_in = '0; b_in = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({alu_a, alu_b, alu_sel, res_data, res_op, res_valid, busy, done, err} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: outputs=%h required all zero",
                     {alu_a, alu_b, alu_sel, res_data, res_op, res_valid, busy, done, err});
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle_busy: busy=%b required 0", busy);
        end
    endtask

    task automatic test_sweep(input logic [7:0] a, input logic [7:0] b,
                              input int stall_op, input int stall_len, input bit poke_busy);
        int rel, extra, waitc;
        bit got;
        logic [7:0] exp_d;
        @(negedge clk);
        a_in = a; b_in = b; start = 1'b1; res_ready = 1'b1;
        @(negedge clk);
        rel = 0; extra = 0;
        n_cmp++;
        if ({busy, alu_a, alu_b, alu_sel, res_valid} !== {1'b1, a, b, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL latch: busy/a/b/sel/valid=%b/%h/%h/%0d/%b required 1/%h/%h/0/0",
                     busy, alu_a, alu_b, alu_sel, res_valid, a, b);
        end
        if (poke_busy) begin
            a_in = 8'h11; b_in = 8'h11; start = 1'b1;
        end else begin
            start = 1'b0; a_in = 8'($urandom); b_in = 8'($urandom);
        end
        for (int op = 0; op < NUM_OPS; op++) begin
            got = 1'b0;
            for (waitc = 0; waitc < 64 && !got; waitc++) begin
                if (res_valid) got = 1'b1;
                else begin
                    @(negedge clk); rel++; start = 1'b0;
                end
            end
            n_cmp++;
            if (!got) begin
                n_fail++;
                $display("FAIL valid_timeout: op=%0d res_valid=%b required 1", op, res_valid);
                return;
            end
            exp_d = (fault_op4 && op == 4) ? 8'h00 : ref_op(int'(a), int'(b), op);
            n_cmp++;
            if ({res_data, res_op} !== {exp_d, 3'(op)} ||
                rel != SETTLE + op * (SETTLE + 1) + extra || err !== exp_err(op)) begin
                n_fail++;
                $display("FAIL result: op=%0d data=%h res_op=%0d cycle=%0d err=%b required data=%h res_op=%0d cycle=%0d err=%b",
                         op, res_data, res_op, rel, err, exp_d, op,
                         SETTLE + op * (SETTLE + 1) + extra, exp_err(op));
            end
            if (op == stall_op && stall_len > 0) begin
                res_ready = 1'b0;
                repeat (stall_len) begin
                    @(negedge clk); rel++;
                    n_cmp++;
                    if ({res_valid, res_data, res_op} !== {1'b1, exp_d, 3'(op)}) begin
                        n_fail++;
                        $display("FAIL stall_hold: valid/data/op=%b/%h/%0d required 1/%h/%0d",
                                 res_valid, res_data, res_op, exp_d, op);
                    end
                end
                res_ready = 1'b1;
                extra += stall_len;
            end
            @(negedge clk); rel++;
        end
        n_cmp++;
        if ({done, busy, res_valid, alu_sel, err} !== {1'b1, 1'b1, 1'b0, 3'(NUM_OPS - 1), exp_err(NUM_OPS - 1)} ||
            rel != NUM_OPS * (SETTLE + 1) + extra) begin
            n_fail++;
            $display("FAIL done_pulse: done/busy/valid/sel/err=%b/%b/%b/%0d/%b cycle=%0d required 1/1/0/%0d/%b cycle=%0d",
                     done, busy, res_valid, alu_sel, err, rel, NUM_OPS - 1,
                     exp_err(NUM_OPS - 1), NUM_OPS * (SETTLE + 1) + extra);
        end
        @(negedge clk);
        n_cmp++;
        if ({done, busy} !== 2'b00) begin
            n_fail++; $display("FAIL done_end: done/busy=%b/%b required 0/0", done, busy);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int waitc;
        @(negedge clk);
        a_in = 8'h3C; b_in = 8'h0F; start = 1'b1; res_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (waitc = 0; waitc < 64 && !(alu_sel == 3'd2 && !res_valid); waitc++) @(negedge clk);
        n_cmp++;
        if (!(alu_sel == 3'd2 && busy && !res_valid)) begin
            n_fail++; $display("FAIL reach_op2: sel=%0d busy=%b required 2/1", alu_sel, busy);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({alu_a, alu_b, alu_sel, res_data, res_op, res_valid, busy, done, err} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: outputs=%h required all zero",
                     {alu_a, alu_b, alu_sel, res_data, res_op, res_valid, busy, done, err});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if ({done, busy, res_valid} !== 3'b000) begin
                n_fail++;
                $display("FAIL post_reset_idle: done/busy/valid=%b/%b/%b required 0/0/0", done, busy, res_valid);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            test_sweep(8'($urandom), 8'($urandom), int'($urandom_range(0, NUM_OPS - 1)),
                       int'($urandom_range(0, 3)), 1'b0);
        end
    endtask

    task automatic test_err_flag();
        fault_op4 = 1'b1;
        test_sweep(8'h3C, 8'h0F, -1, 0, 1'b0);
        fault_op4 = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (err !== 1'b0) begin
            n_fail++; $display("FAIL err_cleared: err=%b required 0", err);
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; fault_op4 = 1'b0;
        test_reset();
        test_sweep(8'h3C, 8'h0F, -1, 0, 1'b0);   // directed sweep
        test_sweep(8'hFF, 8'h01, -1, 0, 1'b0);   // modulo wrap
        test_sweep(8'h3C, 8'h0F, 3, 5, 1'b0);    // backpressure at op3
        test_sweep(8'h5A, 8'hC3, -1, 0, 1'b1);   // start while busy
        test_reset_mid_sweep();
        test_random();
        test_err_flag();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
